// File: rtl/axi_timer_regs.sv
// -----------------------------------------------------------------------------
// axi_timer_regs
//
// AXI4-Lite register front end for timer_core. Bus writes drive the timer's
// enable, reset_counter and prescaler controls; reads return the live counter.
// A compare register feeds a sticky match flag and a registered level irq.
//
// Ports
//   axi_clk, rst_n            clock and asynchronous active-low reset
//   s_axi_aw*                 write address channel (awaddr, awvalid, awready)
//   s_axi_w*                  write data channel (wdata, wstrb, wvalid, wready)
//   s_axi_b*                  write response channel (bresp, bvalid, bready)
//   s_axi_ar*                 read address channel (araddr, arvalid, arready)
//   s_axi_r*                  read data channel (rdata, rresp, rvalid, rready)
//   enable                    CTRL[0] to timer_core
//   reset_counter             one-cycle pulse to timer_core
//   prescaler                 PRESCALER register to timer_core
//   counter                   live count from timer_core
//   irq                       match & irq_en, registered
//
// Register map (byte offsets, bits [4:2] decoded)
//   0x00 CTRL       bit0 enable, bit1 reset_counter (write-only), bit2 irq_en
//   0x04 PRESCALER  32-bit RW
//   0x08 COUNT      RO, writes ignored with OKAY
//   0x0C COMPARE    32-bit RW
//   0x10 STATUS     bit0 match, write-1-to-clear
//   0x14..0x1C      unmapped, SLVERR
// -----------------------------------------------------------------------------
module axi_timer_regs #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  axi_clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  enable,
  output logic                  reset_counter,
  output logic [31:0]           prescaler,
  input  logic [31:0]           counter,
  output logic                  irq
);

  localparam logic [2:0] IDX_CTRL    = 3'd0;
  localparam logic [2:0] IDX_PRESC   = 3'd1;
  localparam logic [2:0] IDX_COUNT   = 3'd2;
  localparam logic [2:0] IDX_COMPARE = 3'd3;
  localparam logic [2:0] IDX_STATUS  = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte-lane merge of new write data into an existing register value.
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = wdat[8*i +: 8];
      end else begin
        res[8*i +: 8] = cur[8*i +: 8];
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  aw_held_r;
  logic [ADDR_WIDTH-1:0] awaddr_r;
  logic                  w_held_r;
  logic [31:0]           wdata_r;
  logic [3:0]            wstrb_r;
  logic                  bvalid_r;
  logic [1:0]            bresp_r;

  logic                  rvalid_r;
  logic [31:0]           rdata_r;
  logic [1:0]            rresp_r;

  logic                  ctrl_enable_r;
  logic                  ctrl_irq_en_r;
  logic                  reset_counter_r;
  logic [31:0]           prescaler_r;
  logic [31:0]           compare_r;
  logic [31:0]           cnt_prev_r;
  logic                  match_r;
  logic                  irq_r;

  // ---------------------------------------------------------------------------
  // Handshakes and commit selection
  // ---------------------------------------------------------------------------
  logic                  awready_s;
  logic                  wready_s;
  logic                  arready_s;
  logic                  aw_hs_s;
  logic                  w_hs_s;
  logic                  ar_hs_s;
  logic                  commit_s;
  logic [ADDR_WIDTH-1:0] cm_addr_s;
  logic [31:0]           cm_data_s;
  logic [3:0]            cm_strb_s;
  logic [2:0]            cm_idx_s;
  logic [2:0]            rd_idx_s;

  // Readys drop while a response is pending so only one write is in flight.
  assign awready_s = !aw_held_r && !bvalid_r;
  assign wready_s  = !w_held_r  && !bvalid_r;
  assign arready_s = !rvalid_r;

  assign aw_hs_s = s_axi_awvalid && awready_s;
  assign w_hs_s  = s_axi_wvalid  && wready_s;
  assign ar_hs_s = s_axi_arvalid && arready_s;

  // Commit on the edge that completes the second half (or both halves at once).
  assign commit_s = (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);

  // Use the held copy of whichever half arrived earlier, else the live bus.
  assign cm_addr_s = aw_held_r ? awaddr_r : s_axi_awaddr;
  assign cm_data_s = w_held_r  ? wdata_r  : s_axi_wdata;
  assign cm_strb_s = w_held_r  ? wstrb_r  : s_axi_wstrb;
  assign cm_idx_s  = cm_addr_s[4:2];
  assign rd_idx_s  = s_axi_araddr[4:2];

  // Byte-offset bits [1:0] and any address bits above [4] carry no meaning.
  logic unused_addr_s;
  assign unused_addr_s = ^{cm_addr_s, s_axi_araddr};

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  logic       wr_ctrl_s;
  logic       wr_presc_s;
  logic       wr_compare_s;
  logic       wr_status_s;
  logic [1:0] wr_resp_s;

  // Select the target register of a committing write and its response code.
  always_comb begin
    wr_ctrl_s    = 1'b0;
    wr_presc_s   = 1'b0;
    wr_compare_s = 1'b0;
    wr_status_s  = 1'b0;
    wr_resp_s    = RESP_OKAY;
    if (commit_s) begin
      case (cm_idx_s)
        IDX_CTRL:    wr_ctrl_s    = 1'b1;
        IDX_PRESC:   wr_presc_s   = 1'b1;
        IDX_COUNT:   wr_resp_s    = RESP_OKAY;
        IDX_COMPARE: wr_compare_s = 1'b1;
        IDX_STATUS:  wr_status_s  = 1'b1;
        default:     wr_resp_s    = RESP_SLVERR;
      endcase
    end else begin
      wr_resp_s = RESP_OKAY;
    end
  end

  // ---------------------------------------------------------------------------
  // Read decode
  // ---------------------------------------------------------------------------
  logic [31:0] rd_data_s;
  logic [1:0]  rd_resp_s;

  // Read mux; the reset_counter bit of CTRL always reads back as zero.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    rd_resp_s = RESP_OKAY;
    case (rd_idx_s)
      IDX_CTRL:    rd_data_s = {29'd0, ctrl_irq_en_r, 1'b0, ctrl_enable_r};
      IDX_PRESC:   rd_data_s = prescaler_r;
      IDX_COUNT:   rd_data_s = counter;
      IDX_COMPARE: rd_data_s = compare_r;
      IDX_STATUS:  rd_data_s = {31'd0, match_r};
      default: begin
        rd_data_s = 32'h0000_0000;
        rd_resp_s = RESP_SLVERR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Latch address/data halves that arrive before their partner; clear on commit.
  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_r <= 1'b0;
      awaddr_r  <= '0;
      w_held_r  <= 1'b0;
      wdata_r   <= 32'h0000_0000;
      wstrb_r   <= 4'h0;
    end else if (commit_s) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
    end else begin
      if (aw_hs_s) begin
        aw_held_r <= 1'b1;
        awaddr_r  <= s_axi_awaddr;
      end
      if (w_hs_s) begin
        w_held_r <= 1'b1;
        wdata_r  <= s_axi_wdata;
        wstrb_r  <= s_axi_wstrb;
      end
    end
  end

  // Write response: raised at commit, held until the master accepts it.
  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_r <= 1'b0;
      bresp_r  <= RESP_OKAY;
    end else if (commit_s) begin
      bvalid_r <= 1'b1;
      bresp_r  <= wr_resp_s;
    end else if (bvalid_r && s_axi_bready) begin
      bvalid_r <= 1'b0;
    end
  end

  // Read response: data captured at the AR handshake and held until rready.
  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      rresp_r  <= RESP_OKAY;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_data_s;
      rresp_r  <= rd_resp_s;
    end else if (rvalid_r && s_axi_rready) begin
      rvalid_r <= 1'b0;
    end
  end

  // Control, prescaler and compare registers; reset_counter is a one-shot.
  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_enable_r   <= 1'b0;
      ctrl_irq_en_r   <= 1'b0;
      reset_counter_r <= 1'b0;
      prescaler_r     <= 32'h0000_0000;
      compare_r       <= 32'h0000_0000;
    end else begin
      reset_counter_r <= wr_ctrl_s && cm_strb_s[0] && cm_data_s[1];
      if (wr_ctrl_s && cm_strb_s[0]) begin
        ctrl_enable_r <= cm_data_s[0];
        ctrl_irq_en_r <= cm_data_s[2];
      end
      if (wr_presc_s) begin
        prescaler_r <= merge_bytes(prescaler_r, cm_data_s, cm_strb_s);
      end
      if (wr_compare_s) begin
        compare_r <= merge_bytes(compare_r, cm_data_s, cm_strb_s);
      end
    end
  end

  // Sticky match on a fresh arrival at COMPARE; a new match beats a W1C clear.
  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_prev_r <= 32'h0000_0000;
      match_r    <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      cnt_prev_r <= counter;
      if ((counter != cnt_prev_r) && (counter == compare_r)) begin
        match_r <= 1'b1;
      end else if (wr_status_s && cm_strb_s[0] && cm_data_s[0]) begin
        match_r <= 1'b0;
      end
      irq_r <= match_r && ctrl_irq_en_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_axi_awready = awready_s;
  assign s_axi_wready  = wready_s;
  assign s_axi_arready = arready_s;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;
  assign enable        = ctrl_enable_r;
  assign reset_counter = reset_counter_r;
  assign prescaler     = prescaler_r;
  assign irq           = irq_r;

endmodule

// File: tb/tb_axi_timer_regs.sv
module tb_axi_timer_regs;

  logic        axi_clk = 1'b0;
  logic        rst_n;
  logic [4:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        enable;
  logic        reset_counter;
  logic [31:0] prescaler;
  logic [31:0] counter;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: expectations pushed at request time, popped at response.
  logic [1:0]  exp_b_q[$];
  logic [31:0] exp_rd_q[$];
  logic [1:0]  exp_rr_q[$];

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  axi_timer_regs #(.ADDR_WIDTH(5)) dut (
    .axi_clk(axi_clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .enable(enable), .reset_counter(reset_counter), .prescaler(prescaler),
    .counter(counter), .irq(irq)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic cyc();
    @(posedge axi_clk);
    #1;
  endtask

  // Drive AW and W together; return 1 ns after the commit edge with bready low.
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er);
    bit aw_d;
    bit w_d;
    int n;
    logic [1:0] e;
    exp_b_q.push_back(er);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    aw_d = 1'b0; w_d = 1'b0; n = 0;
    while (!(aw_d && w_d) && n < 20) begin
      bit aa;
      bit ww;
      aa = awvalid && awready;
      ww = wvalid && wready;
      cyc();
      n++;
      if (aa) begin aw_d = 1'b1; awvalid = 1'b0; end
      if (ww) begin w_d = 1'b1; wvalid = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    checks++; if (!(aw_d && w_d)) begin errors++; $display("FAIL wr_handshake_timeout addr=%0h", a); end
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL wr_bvalid_latency addr=%0h: got %b expected 1", a, bvalid); end
    e = exp_b_q.pop_front();
    checks++; if (bresp !== e) begin errors++; $display("FAIL wr_bresp addr=%0h: got %b expected %b", a, bresp, e); end
  endtask

  task automatic b_ack();
    bready = 1'b1;
    cyc();
    bready = 1'b0;
  endtask

  // Issue a read and compare the response against the scoreboard.
  task automatic axi_read(input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er);
    bit done;
    int n;
    logic [31:0] xd;
    logic [1:0]  xr;
    exp_rd_q.push_back(ed);
    exp_rr_q.push_back(er);
    araddr = a; arvalid = 1'b1; done = 1'b0; n = 0;
    while (!done && n < 20) begin
      bit acc;
      acc = arvalid && arready;
      cyc();
      n++;
      if (acc) begin done = 1'b1; arvalid = 1'b0; end
    end
    arvalid = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL rd_handshake_timeout addr=%0h", a); end
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid_latency addr=%0h: got %b expected 1", a, rvalid); end
    xd = exp_rd_q.pop_front();
    xr = exp_rr_q.pop_front();
    checks++; if (rdata !== xd) begin errors++; $display("FAIL rd_data addr=%0h: got %h expected %h", a, rdata, xd); end
    checks++; if (rresp !== xr) begin errors++; $display("FAIL rd_resp addr=%0h: got %b expected %b", a, rresp, xr); end
    rready = 1'b1;
    cyc();
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    awaddr = 5'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'h0; wvalid = 1'b0;
    bready = 1'b0; araddr = 5'd0; arvalid = 1'b0; rready = 1'b0; counter = 32'd0;
    repeat (2) cyc();
    checks++; if ({enable, reset_counter, irq} !== 3'b000) begin errors++; $display("FAIL rst_ctrl_outs: got %b expected 000", {enable, reset_counter, irq}); end
    checks++; if (prescaler !== 32'd0) begin errors++; $display("FAIL rst_prescaler: got %h expected 0", prescaler); end
    checks++; if ({bvalid, rvalid, bresp, rresp} !== 6'd0) begin errors++; $display("FAIL rst_resp: got %b expected 000000", {bvalid, rvalid, bresp, rresp}); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
    rst_n = 1'b1;
    cyc();
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL rst_readys: got %b expected 111", {awready, wready, arready}); end
  endtask

  task automatic test_same_cycle_write();
    axi_write(5'h04, 32'h0000_0009, 4'hF, OKAY);
    checks++; if (prescaler !== 32'd9) begin errors++; $display("FAIL presc_visible: got %h expected 9", prescaler); end
    b_ack();
    axi_read(5'h04, 32'h0000_0009, OKAY);
  endtask

  task automatic test_w_before_aw();
    logic [1:0] e;
    exp_b_q.push_back(OKAY);
    wdata = 32'h0000_0005; wstrb = 4'hF; wvalid = 1'b1;
    cyc();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bvalid !== 1'b0 || enable !== 1'b0) begin errors++; $display("FAIL wfirst_no_commit cyc%0d: got bvalid=%b enable=%b expected 0 0", i, bvalid, enable); end
      if (i < 2) cyc();
    end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL wfirst_wready: got %b expected 0", wready); end
    awaddr = 5'h00; awvalid = 1'b1;
    cyc();
    awvalid = 1'b0;
    e = exp_b_q.pop_front();
    checks++; if (bvalid !== 1'b1 || bresp !== e) begin errors++; $display("FAIL wfirst_bresp: got v=%b r=%b expected 1 %b", bvalid, bresp, e); end
    checks++; if (enable !== 1'b1 || reset_counter !== 1'b0) begin errors++; $display("FAIL wfirst_ctrl: got en=%b rc=%b expected 1 0", enable, reset_counter); end
    b_ack();
    axi_read(5'h00, 32'h0000_0005, OKAY);
  endtask

  task automatic test_reset_pulse();
    axi_write(5'h00, 32'h0000_0003, 4'hF, OKAY);
    checks++; if (reset_counter !== 1'b1 || enable !== 1'b1) begin errors++; $display("FAIL rcpulse_high: got rc=%b en=%b expected 1 1", reset_counter, enable); end
    b_ack();
    checks++; if (reset_counter !== 1'b0) begin errors++; $display("FAIL rcpulse_low: got %b expected 0", reset_counter); end
    axi_read(5'h00, 32'h0000_0001, OKAY);
  endtask

  task automatic test_strobe_count();
    axi_write(5'h04, 32'hAABB_CCDD, 4'h2, OKAY);
    b_ack();
    axi_read(5'h07, 32'h0000_CC09, OKAY);
    counter = 32'h1234_5678;
    axi_write(5'h08, 32'hFFFF_FFFF, 4'hF, OKAY);
    b_ack();
    axi_read(5'h08, 32'h1234_5678, OKAY);
    checks++; if (prescaler !== 32'h0000_CC09) begin errors++; $display("FAIL count_wr_side_effect: got %h expected 0000cc09", prescaler); end
  endtask

  task automatic test_match_irq();
    axi_write(5'h00, 32'h0000_0005, 4'hF, OKAY); b_ack();
    axi_write(5'h0C, 32'h0000_0004, 4'hF, OKAY); b_ack();
    counter = 32'd3;
    cyc();
    counter = 32'd4;
    cyc();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq); end
    cyc();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", irq); end
    axi_read(5'h10, 32'h0000_0001, OKAY);
    axi_write(5'h10, 32'h0000_0001, 4'hF, OKAY);
    b_ack();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b expected 0", irq); end
    axi_read(5'h10, 32'h0000_0000, OKAY);
    counter = 32'd3;
    cyc(); cyc();
    counter = 32'd4;
    axi_write(5'h10, 32'h0000_0001, 4'hF, OKAY);
    b_ack();
    axi_read(5'h10, 32'h0000_0001, OKAY);
  endtask

  task automatic test_unmapped();
    axi_read(5'h14, 32'h0000_0000, SLVERR);
    axi_write(5'h18, 32'hFFFF_FFFF, 4'hF, SLVERR);
    b_ack();
    checks++; if (prescaler !== 32'h0000_CC09 || enable !== 1'b1) begin errors++; $display("FAIL unmapped_side_effect: got p=%h en=%b expected 0000cc09 1", prescaler, enable); end
    axi_read(5'h0C, 32'h0000_0004, OKAY);
    axi_read(5'h00, 32'h0000_0005, OKAY);
  endtask

  task automatic test_bready_hold_reset();
    axi_write(5'h04, 32'h0000_0077, 4'hF, OKAY);
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if ({bvalid, awready, wready} !== 3'b100) begin errors++; $display("FAIL bhold cyc%0d: got %b expected 100", i, {bvalid, awready, wready}); end
    end
    rst_n = 1'b0;
    #1;
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL rst_abort_bvalid: got %b expected 0", bvalid); end
    checks++; if ({prescaler, enable, irq} !== 34'd0) begin errors++; $display("FAIL rst_abort_regs: got p=%h en=%b irq=%b expected 0", prescaler, enable, irq); end
    cyc();
    rst_n = 1'b1;
    cyc();
    checks++; if ({awready, wready, bvalid} !== 3'b110) begin errors++; $display("FAIL post_rst_readys: got %b expected 110", {awready, wready, bvalid}); end
    axi_read(5'h0C, 32'h0000_0000, OKAY);
    axi_read(5'h10, 32'h0000_0000, OKAY);
    axi_read(5'h00, 32'h0000_0000, OKAY);
  endtask

  initial begin
    test_reset();
    test_same_cycle_write();
    test_w_before_aw();
    test_reset_pulse();
    test_strobe_count();
    test_match_irq();
    test_unmapped();
    test_bready_hold_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_timer_regs.md
# axi_timer_regs

AXI4-Lite responder that fronts `timer_core`: it decodes bus writes into the timer's `enable`, `reset_counter` and `prescaler` controls, and returns the live `counter` value on reads. It also provides a compare register with a sticky match flag and a level interrupt. It sits between the system AXI4-Lite interconnect and `timer_core`, in the same `axi_clk` domain.

## Interface
- ADDR_WIDTH, 5, byte-address width of `s_axi_awaddr` and `s_axi_araddr`; only bits [4:2] are decoded.
- axi_clk  in  1  clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- s_axi_awaddr  in  ADDR_WIDTH  write address. s_axi_awvalid in 1; s_axi_awready out 1.
- s_axi_wdata  in  32  write data. s_axi_wstrb in 4; s_axi_wvalid in 1; s_axi_wready out 1.
- s_axi_bresp  out  2  write response. s_axi_bvalid out 1; s_axi_bready in 1.
- s_axi_araddr  in  ADDR_WIDTH  read address. s_axi_arvalid in 1; s_axi_arready out 1.
- s_axi_rdata  out  32  read data. s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1.
- enable  out  1  to `timer_core`; equals CTRL[0].
- reset_counter  out  1  to `timer_core`; one-cycle pulse.
- prescaler  out  32  to `timer_core`; equals the PRESCALER register.
- counter  in  32  from `timer_core`.
- irq  out  1  registered level interrupt.

## Operation
Register map (byte offsets):
- 0x00 CTRL (RW). bit0 = enable, bit1 = reset_counter, bit2 = irq_en.
  - bit1 is write-only. Writing 1 produces a one-cycle `reset_counter` pulse. It always reads 0.
- 0x04 PRESCALER (RW, 32 bits).
- 0x08 COUNT (RO). Reads return `counter`; writes are ignored with response OKAY.
- 0x0C COMPARE (RW, 32 bits).
- 0x10 STATUS. bit0 = match, write-1-to-clear (W1C). Other bits read 0.
- 0x14–0x1C: unmapped. Reads return rdata 0 with SLVERR; writes have no effect and return SLVERR.

Write behaviour:
- RW registers honour `wstrb` per byte.
- The CTRL bits and STATUS W1C take effect only when `wstrb[0]`=1.
- Address bits [1:0] are ignored.

Match and interrupt:
- Register `cnt_prev` <= `counter` every cycle.
- match sets when `counter != cnt_prev` && `counter == COMPARE`.
- If a set and a W1C clear occur in the same cycle, the set wins.
- `irq` <= match & irq_en, registered.

Write channel (AW and W are independent; they may arrive in either order or together):
- Internal flags `aw_held` and `w_held` latch the address, data and strobe on each handshake.
- `awready` = !aw_held && !bvalid.
- `wready` = !w_held && !bvalid.
- The write commits at the edge where the second of the two handshakes completes; if both complete on the same edge, it commits on that edge.
  - At that edge the register is updated, `bvalid` is set, `bresp` is set, and both held flags clear.
- `bvalid` holds until `bready`. While `bvalid`=1, both readys stay 0, so only one write is outstanding.

Read channel:
- `arready` = !rvalid.
- At the AR handshake edge, `rdata` and `rresp` are captured and `rvalid` is set.
- `rvalid` holds, with data stable, until `rready`.
- Reads and writes proceed concurrently. A read of a register that commits on the same edge returns the old value.

## Timing
- Reset values:
  - CTRL, PRESCALER and COMPARE are 0; match is 0.
  - `enable`, `reset_counter`, `prescaler` and `irq` are 0.
  - `bvalid`, `rvalid`, `bresp`, `rresp` and `rdata` are 0.
  - `awready`, `wready` and `arready` are 1 once `rst_n` is high.
- Reset asserted mid-transaction aborts it: held flags and valids clear immediately and no response is issued.
- Write latency: `bvalid` rises 1 cycle after the last of the AW/W handshakes. The register value is visible on the outputs in that same cycle.
- CTRL write with bit1=1: `reset_counter`=1 for exactly the one cycle after commit, then 0. `enable` updates in the same cycle.
- Read latency: `rvalid` rises 1 cycle after the AR handshake. COUNT returns the `counter` value sampled at the handshake edge.
- `irq` rises 2 cycles after `counter` first equals COMPARE: match sets on the first edge, `irq` follows on the next. It falls 1 cycle after the W1C commit, or 1 cycle after irq_en is cleared.
- Back-to-back throughput: one write per 2 cycles when `bready` is held at 1; one read per 2 cycles when `rready` is held at 1.

## Test plan
- AW and W on the same cycle to 0x04, data 0x0000_0009, wstrb 0xF -> `prescaler`=9 and `bvalid`=1 one cycle later, bresp=OKAY. A read of 0x04 returns 9.
- W issued 3 cycles before AW to 0x00, data 0x5 -> no commit until AW. Then `enable`=1, irq_en=1, `reset_counter` stays 0. A read of 0x00 returns 0x5.
- Write 0x00 with data 0x3 -> `reset_counter` high for exactly 1 cycle and `enable`=1. A subsequent read of 0x00 returns 0x1.
- COMPARE=4 with irq_en=1; drive `counter` 3→4 -> STATUS reads 1 and `irq`=1 two cycles later. A W1C of 0x1 to 0x10 -> `irq`=0 one cycle after commit. A W1C on the same cycle as a new match leaves match=1.
- Read of 0x14 -> rdata 0, rresp=SLVERR. Write to 0x18 -> bresp=SLVERR with no register changed.
- Hold `bready`=0 for 5 cycles after a write -> `bvalid` stays 1 and `awready`/`wready` stay 0. Assert `rst_n`=0 mid-hold -> `bvalid`=0 immediately and all registers reset to 0.
